// File: rtl/fp_sort_pkg.sv
// Shared types for the float batch sorter.
// Word type, comparator result encoding and controller states.
package fp_sort_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    xGTy     = 2'd0,
    xEQy     = 2'd1,
    xLTy     = 2'd2,
    noResult = 2'd3
  } compareResults;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } sort_state_t;

endpackage

// File: rtl/fp_sort_cmp.sv
// Combinational 3-way compare of two IEEE-754 single words.
// Sign first, then exponent/mantissa as one field; negatives invert.
module fp_sort_cmp
  import fp_sort_pkg::*;
(
  input  fp32_t         value_x,
  input  fp32_t         value_y,
  output compareResults result
);

  logic mag_gt;

  always_comb begin
    result = noResult;
    mag_gt = value_x[30:0] > value_y[30:0];
    if (value_x == value_y)
      result = xEQy;
    else if (value_x[31] != value_y[31])
      result = value_x[31] ? xLTy : xGTy;
    else if (mag_gt ^ value_x[31])
      result = xGTy;
    else
      result = xLTy;
  end

endmodule

// File: rtl/fp_sort_ctrl.sv
// Batch float sorter: load, odd-even transposition sort, drain.
// FP_SORT_SWAPCNT_EN adds a saturating swap counter output.
module fp_sort_ctrl
  import fp_sort_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
`ifdef FP_SORT_SWAPCNT_EN
  ,
  output logic [15:0] swap_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] LST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEP = CNT_W'(DEPTH);

  sort_state_t      state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] i;
  logic [CNT_W-1:0] iy;
  logic [CNT_W-1:0] rd;
  logic [CNT_W:0]   i3;
  fp32_t            sbuf [DEPTH];
  fp32_t            vx;
  fp32_t            vy;
  compareResults    res;
  logic             acc;
  logic             done_load;
  logic             pair_ok;
  logic             swap;
  logic             pass_end;
  logic             last_pass;

  assign acc       = (state == LOAD) && in_valid;
  assign done_load = acc && (in_last || count == LST);
  assign iy        = i + ONE;
  assign i3        = {1'b0, i} + (CNT_W + 1)'(3);
  assign pair_ok   = iy < count;
  assign pass_end  = !(i3 < {1'b0, count});
  assign last_pass = p == (count - ONE);

  // n==2 has an empty odd pass; it still costs one idle cycle.
  assign vx = sbuf[i[IDX_W-1:0]];
  assign vy = (iy < DEP) ? sbuf[iy[IDX_W-1:0]] : vx;

  fp_sort_cmp u_cmp (
    .value_x (vx),
    .value_y (vy),
    .result  (res)
  );

  assign swap = (state == SORT) && pair_ok && (res == xGTy);

  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  assign out_last  = (state == DRAIN) && (rd == count - ONE);
  assign out_data  = out_valid ? sbuf[rd[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      count <= '0;
      rd    <= '0;
      p     <= '0;
      i     <= '0;
    end else begin
      unique case (state)
        LOAD: if (acc) begin
          count <= count + ONE;
          if (done_load) begin
            p     <= '0;
            i     <= '0;
            rd    <= '0;
            state <= (count == '0) ? DRAIN : SORT;
          end
        end
        SORT: if (pass_end) begin
          if (last_pass) begin
            state <= DRAIN;
            rd    <= '0;
          end else begin
            p <= p + ONE;
            i <= {{(CNT_W-1){1'b0}}, ~p[0]};
          end
        end else begin
          i <= i + TWO;
        end
        DRAIN: if (out_ready) begin
          rd <= rd + ONE;
          if (out_last) begin
            state <= LOAD;
            count <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      sbuf[count[IDX_W-1:0]] <= in_data;
    end else if (swap) begin
      sbuf[i[IDX_W-1:0]]  <= vy;
      sbuf[iy[IDX_W-1:0]] <= vx;
    end
  end

`ifdef FP_SORT_SWAPCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      swap_cnt <= '0;
    else if (acc && count == '0)
      swap_cnt <= '0;
    else if (swap && swap_cnt != 16'hFFFF)
      swap_cnt <= swap_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fp_sort_ctrl.sv
// Randomized self-checking bench for fp_sort_ctrl.
// Reference: stable sort on an order-preserving integer key.
module tb_fp_sort_ctrl;
  import fp_sort_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef FP_SORT_SWAPCNT_EN
  logic [15:0] swap_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FP_SORT_SWAPCNT_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Maps float bits to an unsigned key with the same total order.
  function automatic logic [31:0] key(input fp32_t x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic int exp_sort_cyc(input int n);
    int tot;
    int pr;
    tot = 0;
    if (n < 2) return 0;
    for (int p = 0; p < n; p++) begin
      pr = 0;
      for (int j = p % 2; j + 1 < n; j += 2) pr++;
      tot += (pr == 0) ? 1 : pr;
    end
    return tot;
  endfunction

  function automatic int inversions(input fp32_t w[$]);
    int c;
    c = 0;
    for (int a = 0; a < w.size(); a++)
      for (int b = a + 1; b < w.size(); b++)
        if (key(w[a]) > key(w[b])) c++;
    return c;
  endfunction

  task automatic send(input fp32_t w, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = l;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_batch(input fp32_t w[$], input bit stall);
    fp32_t ex[$];
    fp32_t tmp;
    fp32_t pd;
    logic  pl;
    bit    stalled;
    int    n, cyc, extra, k, t, j;
    n = (w.size() > DEPTH) ? DEPTH : w.size();
    for (int a = 0; a < n; a++) ex.push_back(w[a]);
    for (int a = 1; a < n; a++) begin
      tmp = ex[a];
      j = a - 1;
      while (j >= 0 && key(ex[j]) > key(tmp)) begin
        ex[j+1] = ex[j];
        j--;
      end
      ex[j+1] = tmp;
    end
    for (int a = 0; a < n; a++)
      send(w[a], (w.size() <= DEPTH) && (a == n - 1));
    if (w.size() > DEPTH) begin
      chk("trunc_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_data  = w[DEPTH];
    end
    cyc = 0;
    extra = 0;
    while (!out_valid && cyc < 2000) begin
      if (in_valid && in_ready) extra++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("sort_cycles", cyc, exp_sort_cyc(n));
    chk("extra_accept", extra, 0);
    chk("busy_drain", {31'd0, busy}, 32'd1);
    k = 0;
    t = 0;
    while (k < n && t < 2000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, ex[k]);
        chk("out_last", {31'd0, out_last}, {31'd0, k == n - 1});
        k++;
      end
      stalled = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      step();
      t++;
      if (stalled) begin
        chk("hold_data", out_data, pd);
        chk("hold_last", {31'd0, out_last}, {31'd0, pl});
      end
    end
    out_ready = 1'b0;
    chk("beats", k, n);
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_ready", {31'd0, in_ready}, 32'd1);
`ifdef FP_SORT_SWAPCNT_EN
    ex.delete();
    for (int a = 0; a < n; a++) ex.push_back(w[a]);
    chk("swap_cnt", {16'd0, swap_cnt}, inversions(ex));
`endif
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fp32_t w[$];
    fp32_t pool[8];
    int    len, t;
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000,
             32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000,
             32'h7FC0_0000, 32'h4000_0000};
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", out_data, 32'd0);
`ifdef FP_SORT_SWAPCNT_EN
    chk("rst_swap", {16'd0, swap_cnt}, 32'd0);
`endif
    reset = 1'b0;

    w = '{32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h3F80_0000};
    run_batch(w, 1'b0);
    w = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000};
    run_batch(w, 1'b0);
    w = '{32'h3F80_0000};
    run_batch(w, 1'b0);
    w = '{32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000,
          32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000,
          32'h4110_0000, 32'h4120_0000};
    run_batch(w, 1'b0);
    w = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    run_batch(w, 1'b1);

    w = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000};
    for (int a = 0; a < 4; a++) send(w[a], a == 3);
    step();
    step();
    chk("mid_sort_busy", {31'd0, busy}, 32'd1);
    reset_pulse("rst_sort");
    w = '{32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    for (int a = 0; a < 3; a++) send(w[a], a == 2);
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    chk("drain_reached", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    reset_pulse("rst_drain");
    w = '{32'h4040_0000, 32'h3F80_0000};
    run_batch(w, 1'b1);

    for (int b = 0; b < 25; b++) begin
      w.delete();
      len = $urandom_range(1, 10);
      for (int a = 0; a < len; a++) begin
        case ($urandom_range(0, 3))
          0: w.push_back($urandom);
          1: w.push_back(pool[$urandom_range(0, 7)]);
          2: w.push_back(32'h3F80_0000 + 32'($urandom_range(0, 3)));
          default: w.push_back($urandom | 32'h8000_0000);
        endcase
      end
      run_batch(w, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
